cpu_controller: RTL and testbench

- Moore FSM that sequences one instruction through the datapath.
- It consumes the decoded opcode and ALU_op fields from idecoder.
- It drives reg_sel back to idecoder, which uses it to choose the Rn, Rd or Rm field for r_addr/w_addr.
- It also drives every datapath enable and mux select, and raises waiting when idle.

---
 rtl/cpu_controller.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_cpu_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_controller.sv
//------------------------------------------------------------------------------
// cpu_controller
//
// Moore FSM that sequences one instruction through the datapath.  The decoded
// opcode / ALU_op fields are sampled once, in DECODE, and folded into a
// registered instruction class.  Every later state follows that class, so IR
// changes after DECODE cannot alter the sequence.
//
// All outputs are registered.  Each cycle the FSM decodes the value the state
// register is about to take.  The outputs therefore track the state register
// exactly, and no input has a combinational path to an output.
//
// Optional feature (macro CTRL_ILLEGAL_TRAP_EN):
//   defined   - an illegal code parks the FSM in TRAP.  The sticky 'illegal'
//               flag is set, and only rst_n leaves TRAP.
//   undefined - an illegal code is a 2-cycle NOP (WAIT, DECODE, WAIT) with no
//               writes; 'illegal' is tied to 0.
//
// Parameters:
//   CNT_W      width of the retired-instruction counter
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      begin the instruction in the IR (sampled only in WAIT)
//   opcode     decoded ir[15:13]
//   ALU_op     decoded ir[12:11]
//   waiting    high only in WAIT
//   reg_sel    register field select: 10 = Rn, 01 = Rd, 00 = Rm
//   wb_sel     writeback source: 00 = datapath C, 10 = sximm8
//   w_en       register-file write enable
//   en_A       load register A
//   en_B       load register B
//   en_C       load register C
//   en_status  load Z/N/V status
//   sel_A      1 = A operand is zero
//   sel_B      1 = B operand is sximm5 (always 0 for the current ISA)
//   retired    count of completed instructions (wraps)
//   illegal    sticky illegal-opcode flag
//------------------------------------------------------------------------------
module cpu_controller #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       opcode,
   input  logic [1:0]       ALU_op,
   output logic             waiting,
   output logic [1:0]       reg_sel,
   output logic [1:0]       wb_sel,
   output logic             w_en,
   output logic             en_A,
   output logic             en_B,
   output logic             en_C,
   output logic             en_status,
   output logic             sel_A,
   output logic             sel_B,
   output logic [CNT_W-1:0] retired,
   output logic             illegal
);

   typedef enum logic [3:0] {
      S_WAIT   = 4'd0,
      S_DECODE = 4'd1,
      S_WR_IMM = 4'd2,
      S_GET_A  = 4'd3,
      S_GET_B  = 4'd4,
      S_CALC   = 4'd5,
      S_CALC_S = 4'd6,
      S_WR_REG = 4'd7,
      S_TRAP   = 4'd8
   } state_t;

   // Instruction class latched in DECODE.
   // C_MOV is MOV reg: its CALC step forces the A operand to zero.
   typedef enum logic [1:0] {
      C_ALU  = 2'd0,
      C_CMP  = 2'd1,
      C_MOV  = 2'd2,
      C_NONE = 2'd3
   } cls_t;

   typedef struct packed {
      logic       waiting;
      logic [1:0] reg_sel;
      logic [1:0] wb_sel;
      logic       w_en;
      logic       en_A;
      logic       en_B;
      logic       en_C;
      logic       en_status;
      logic       sel_A;
      logic       sel_B;
   } ctrl_t;

   localparam logic [1:0] SEL_RN = 2'b10;
   localparam logic [1:0] SEL_RD = 2'b01;
   localparam logic [1:0] SEL_RM = 2'b00;
   localparam logic [1:0] WB_C   = 2'b00;
   localparam logic [1:0] WB_IMM = 2'b10;

   localparam ctrl_t CTRL_IDLE = 13'b0_00_00_0_0_0_0_0_0_0;
   localparam ctrl_t CTRL_WAIT = 13'b1_00_00_0_0_0_0_0_0_0;

   state_t           state_r;
   state_t           state_nxt_s;
   cls_t             cls_r;
   cls_t             cls_nxt_s;
   ctrl_t            ctrl_r;
   ctrl_t            ctrl_nxt_s;
   logic             retire_s;
   logic [CNT_W-1:0] retired_r;

   // Output pattern for a given state; anything not listed stays 0.
   function automatic ctrl_t decode_ctrl(input state_t st, input cls_t cls);
      ctrl_t c;
      c = CTRL_IDLE;
      case (st)
         S_WAIT: begin
            c.waiting = 1'b1;
         end
         S_WR_IMM: begin
            c.reg_sel = SEL_RN;
            c.wb_sel  = WB_IMM;
            c.w_en    = 1'b1;
         end
         S_GET_A: begin
            c.reg_sel = SEL_RN;
            c.en_A    = 1'b1;
         end
         S_GET_B: begin
            c.reg_sel = SEL_RM;
            c.en_B    = 1'b1;
         end
         S_CALC: begin
            c.en_C  = 1'b1;
            c.sel_A = (cls == C_MOV) ? 1'b1 : 1'b0;
         end
         S_CALC_S: begin
            c.en_status = 1'b1;
         end
         S_WR_REG: begin
            c.reg_sel = SEL_RD;
            c.wb_sel  = WB_C;
            c.w_en    = 1'b1;
         end
         default: begin
            c = CTRL_IDLE;
         end
      endcase
      return c;
   endfunction

   // Next-state, next-class and next-output decode.
   always_comb begin
      state_nxt_s = state_r;
      cls_nxt_s   = cls_r;
      retire_s    = 1'b0;
      case (state_r)
         S_WAIT: begin
            if (start) begin
               state_nxt_s = S_DECODE;
            end else begin
               state_nxt_s = S_WAIT;
            end
         end
         S_DECODE: begin
            case ({opcode, ALU_op})
               5'b110_10: begin
                  state_nxt_s = S_WR_IMM;
                  cls_nxt_s   = C_NONE;
               end
               5'b110_00: begin
                  state_nxt_s = S_GET_B;
                  cls_nxt_s   = C_MOV;
               end
               5'b101_00, 5'b101_10: begin
                  state_nxt_s = S_GET_A;
                  cls_nxt_s   = C_ALU;
               end
               5'b101_01: begin
                  state_nxt_s = S_GET_A;
                  cls_nxt_s   = C_CMP;
               end
               5'b101_11: begin
                  state_nxt_s = S_GET_B;
                  cls_nxt_s   = C_ALU;
               end
               default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                  state_nxt_s = S_TRAP;
`else
                  state_nxt_s = S_WAIT;
`endif
                  cls_nxt_s   = C_NONE;
               end
            endcase
         end
         S_WR_IMM: begin
            state_nxt_s = S_WAIT;
            retire_s    = 1'b1;
         end
         S_GET_A: begin
            state_nxt_s = S_GET_B;
         end
         S_GET_B: begin
            if (cls_r == C_CMP) begin
               state_nxt_s = S_CALC_S;
            end else begin
               state_nxt_s = S_CALC;
            end
         end
         S_CALC: begin
            state_nxt_s = S_WR_REG;
         end
         S_CALC_S: begin
            state_nxt_s = S_WAIT;
            retire_s    = 1'b1;
         end
         S_WR_REG: begin
            state_nxt_s = S_WAIT;
            retire_s    = 1'b1;
         end
         S_TRAP: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            state_nxt_s = S_TRAP;
`else
            state_nxt_s = S_WAIT;
`endif
         end
         default: begin
            state_nxt_s = S_WAIT;
         end
      endcase
      ctrl_nxt_s = decode_ctrl(state_nxt_s, cls_nxt_s);
   end

   // State, class, registered outputs and retired counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= S_WAIT;
         cls_r     <= C_NONE;
         ctrl_r    <= CTRL_WAIT;
         retired_r <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         cls_r   <= cls_nxt_s;
         ctrl_r  <= ctrl_nxt_s;
         if (retire_s) begin
            retired_r <= retired_r + CNT_W'(1'b1);
         end else begin
            retired_r <= retired_r;
         end
      end
   end

`ifdef CTRL_ILLEGAL_TRAP_EN
   logic illegal_r;

   // Sticky flag, raised as the FSM enters TRAP; only reset clears it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         illegal_r <= 1'b0;
      end else if (state_nxt_s == S_TRAP) begin
         illegal_r <= 1'b1;
      end else begin
         illegal_r <= illegal_r;
      end
   end

   assign illegal = illegal_r;
`else
   assign illegal = 1'b0;
`endif

   assign waiting   = ctrl_r.waiting;
   assign reg_sel   = ctrl_r.reg_sel;
   assign wb_sel    = ctrl_r.wb_sel;
   assign w_en      = ctrl_r.w_en;
   assign en_A      = ctrl_r.en_A;
   assign en_B      = ctrl_r.en_B;
   assign en_C      = ctrl_r.en_C;
   assign en_status = ctrl_r.en_status;
   assign sel_A     = ctrl_r.sel_A;
   assign sel_B     = ctrl_r.sel_B;
   assign retired   = retired_r;

endmodule

// File: tb/tb_cpu_controller.sv
//------------------------------------------------------------------------------
// tb_cpu_controller
//
// Scoreboard bench for cpu_controller, instantiated with CNT_W = 2 so that the
// retired counter wraps quickly.
//
// The stimulus drives inputs 1 time unit after each rising edge.  At the same
// moment it pushes the expected output vector for the state now in the
// register: {ctrl fields, retired, illegal}.  A monitor pops one entry on each
// falling edge and compares it against the DUT outputs.
//------------------------------------------------------------------------------
module tb_cpu_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [2:0] opcode;
   logic [1:0] ALU_op;
   logic       waiting;
   logic [1:0] reg_sel;
   logic [1:0] wb_sel;
   logic       w_en;
   logic       en_A;
   logic       en_B;
   logic       en_C;
   logic       en_status;
   logic       sel_A;
   logic       sel_B;
   logic [1:0] retired;
   logic       illegal;

   always #5 clk = ~clk;

   cpu_controller #(.CNT_W(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .opcode    (opcode),
      .ALU_op    (ALU_op),
      .waiting   (waiting),
      .reg_sel   (reg_sel),
      .wb_sel    (wb_sel),
      .w_en      (w_en),
      .en_A      (en_A),
      .en_B      (en_B),
      .en_C      (en_C),
      .en_status (en_status),
      .sel_A     (sel_A),
      .sel_B     (sel_B),
      .retired   (retired),
      .illegal   (illegal)
   );

   // Expected per-state outputs:
   // {waiting, reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B}
   localparam logic [12:0] P_WAIT  = 13'b1_00_00_0_0_0_0_0_0_0;
   localparam logic [12:0] P_DEC   = 13'b0_00_00_0_0_0_0_0_0_0;
   localparam logic [12:0] P_WRIMM = 13'b0_10_10_1_0_0_0_0_0_0;
   localparam logic [12:0] P_GETA  = 13'b0_10_00_0_1_0_0_0_0_0;
   localparam logic [12:0] P_GETB  = 13'b0_00_00_0_0_1_0_0_0_0;
   localparam logic [12:0] P_CALC  = 13'b0_00_00_0_0_0_1_0_0_0;
   localparam logic [12:0] P_CALCM = 13'b0_00_00_0_0_0_1_0_1_0;
   localparam logic [12:0] P_CALCS = 13'b0_00_00_0_0_0_0_1_0_0;
   localparam logic [12:0] P_WRREG = 13'b0_01_00_1_0_0_0_0_0_0;
   localparam logic [12:0] P_TRAP  = 13'b0_00_00_0_0_0_0_0_0_0;

   typedef struct {
      logic [15:0] vec;
      string       tag;
   } exp_t;

   exp_t        exp_q[$];
   int          checks   = 0;
   int          failures = 0;
   int          exp_ret  = 0;
   logic        exp_ill  = 1'b0;
   logic [15:0] act_s;

   assign act_s = {waiting, reg_sel, wb_sel, w_en, en_A, en_B, en_C,
                   en_status, sel_A, sel_B, retired, illegal};

   // Monitor: pop one expectation per falling edge and compare.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (act_s !== e.vec) begin
            failures++;
            $display("FAIL %s: got %b expected %b (waiting,reg_sel,wb_sel,w_en,A,B,C,st,selA,selB,retired,illegal)",
                     e.tag, act_s, e.vec);
         end
      end
   end

   // Push the expectation for the current state, drive inputs for the next edge.
   task automatic cyc(input logic [12:0] ph, input string tag, input logic rst_v,
                      input logic st, input logic [2:0] op, input logic [1:0] alu);
      exp_t e;
      e.vec = {ph, exp_ret[1:0], exp_ill};
      e.tag = tag;
      exp_q.push_back(e);
      rst_n  = rst_v;
      start  = st;
      opcode = op;
      ALU_op = alu;
      @(posedge clk);
      #1;
   endtask

   task automatic bump_retired();
      exp_ret = (exp_ret + 1) % 4;
   endtask

   // One legal instruction from its WAIT cycle; hold = start level after WAIT.
   task automatic run(input string nm, input logic [2:0] op, input logic [1:0] alu,
                      input logic hold);
      cyc(P_WAIT, {nm, ".wait"}, 1'b1, 1'b1, op, alu);
      cyc(P_DEC,  {nm, ".dec"},  1'b1, hold, op, alu);
      if (op == 3'b110 && alu == 2'b10) begin
         cyc(P_WRIMM, {nm, ".wrimm"}, 1'b1, hold, op, alu);
      end else if (op == 3'b110) begin
         cyc(P_GETB,  {nm, ".getb"},  1'b1, hold, op, alu);
         cyc(P_CALCM, {nm, ".calc"},  1'b1, hold, op, alu);
         cyc(P_WRREG, {nm, ".wrreg"}, 1'b1, hold, op, alu);
      end else if (alu == 2'b01) begin
         cyc(P_GETA,  {nm, ".geta"},  1'b1, hold, op, alu);
         cyc(P_GETB,  {nm, ".getb"},  1'b1, hold, op, alu);
         cyc(P_CALCS, {nm, ".calcs"}, 1'b1, hold, op, alu);
      end else if (alu == 2'b11) begin
         cyc(P_GETB,  {nm, ".getb"},  1'b1, hold, op, alu);
         cyc(P_CALC,  {nm, ".calc"},  1'b1, hold, op, alu);
         cyc(P_WRREG, {nm, ".wrreg"}, 1'b1, hold, op, alu);
      end else begin
         cyc(P_GETA,  {nm, ".geta"},  1'b1, hold, op, alu);
         cyc(P_GETB,  {nm, ".getb"},  1'b1, hold, op, alu);
         cyc(P_CALC,  {nm, ".calc"},  1'b1, hold, op, alu);
         cyc(P_WRREG, {nm, ".wrreg"}, 1'b1, hold, op, alu);
      end
      bump_retired();
   endtask

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      opcode = 3'b000;
      ALU_op = 2'b00;
      @(posedge clk);
      #1;

      // The reset state is checked by the first WAIT entry of this run.
      run("movi", 3'b110, 2'b10, 1'b0);  // retired -> 1
      run("add",  3'b101, 2'b00, 1'b0);  // -> 2
      run("cmp",  3'b101, 2'b01, 1'b0);  // -> 3
      run("movr", 3'b110, 2'b00, 1'b0);  // -> 0 (wrap)
      run("mvn",  3'b101, 2'b11, 1'b0);  // -> 1
      run("and",  3'b101, 2'b10, 1'b0);  // -> 2

      // ADD with start pulsed and the IR changed once DECODE has passed.
      cyc(P_WAIT,  "dist.wait",  1'b1, 1'b1, 3'b101, 2'b00);
      cyc(P_DEC,   "dist.dec",   1'b1, 1'b0, 3'b101, 2'b00);
      cyc(P_GETA,  "dist.geta",  1'b1, 1'b0, 3'b101, 2'b00);
      cyc(P_GETB,  "dist.getb",  1'b1, 1'b1, 3'b110, 2'b10);
      cyc(P_CALC,  "dist.calc",  1'b1, 1'b0, 3'b110, 2'b00);
      cyc(P_WRREG, "dist.wrreg", 1'b1, 1'b0, 3'b110, 2'b00);
      bump_retired();                    // -> 3

      run("movi2", 3'b110, 2'b10, 1'b0); // -> 0

      // Reset during CALC of an ADD: no write, next cycle is WAIT, count stays 0.
      cyc(P_WAIT, "rstmid.wait", 1'b1, 1'b1, 3'b101, 2'b00);
      cyc(P_DEC,  "rstmid.dec",  1'b1, 1'b0, 3'b101, 2'b00);
      cyc(P_GETA, "rstmid.geta", 1'b1, 1'b0, 3'b101, 2'b00);
      cyc(P_GETB, "rstmid.getb", 1'b1, 1'b0, 3'b101, 2'b00);
      cyc(P_CALC, "rstmid.calc", 1'b0, 1'b0, 3'b101, 2'b00);

      // Five back-to-back MOV imm with start held high: 1, 2, 3, 0, 1.
      for (int i = 0; i < 5; i++) begin
         run($sformatf("b2b%0d", i), 3'b110, 2'b10, 1'b1);
      end

`ifdef CTRL_ILLEGAL_TRAP_EN
      // Illegal code traps; start is ignored until reset.
      cyc(P_WAIT, "ill.wait", 1'b1, 1'b1, 3'b111, 2'b00);
      cyc(P_DEC,  "ill.dec",  1'b1, 1'b1, 3'b111, 2'b00);
      exp_ill = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc(P_TRAP, "ill.trap", 1'b1, 1'b1, 3'b110, 2'b10);
      end
      cyc(P_TRAP, "ill.trap_rst", 1'b0, 1'b0, 3'b110, 2'b10);
      exp_ill = 1'b0;
      exp_ret = 0;
      run("movi_after", 3'b110, 2'b10, 1'b0);
`else
      // Illegal codes are 2-cycle NOPs: no write, no retire.
      cyc(P_WAIT, "ill.wait", 1'b1, 1'b1, 3'b111, 2'b00);
      cyc(P_DEC,  "ill.dec",  1'b1, 1'b0, 3'b111, 2'b00);
      cyc(P_WAIT, "ill2.wait", 1'b1, 1'b1, 3'b110, 2'b01);
      cyc(P_DEC,  "ill2.dec",  1'b1, 1'b0, 3'b110, 2'b01);
      run("movi_after", 3'b110, 2'b10, 1'b0);
`endif
      cyc(P_WAIT, "final.wait", 1'b1, 1'b0, 3'b000, 2'b00);

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
         @(posedge clk);
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
